argmax_classifier: RTL and testbench



---
 rtl/argmax_classifier.sv | 122 ++++++++++++
 tb/tb_argmax_classifier.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// Streaming argmax over one frame of signed classifier scores.
// Presents the winning index/score on a held output handshake and flags frames of the wrong length.
module argmax_classifier #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_OUTPUTS = 10,
    parameter int unsigned IDX_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_class,
    output logic [DATA_WIDTH-1:0] out_score,
    output logic                  out_err
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OUTPUTS - 1);

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_RESULT = 1'b1
    } state_t;

    state_t                  state_q;
    logic [IDX_WIDTH-1:0]    idx_q;
    logic [IDX_WIDTH-1:0]    idx_d;
    logic [DATA_WIDTH-1:0]   max_q;
    logic [DATA_WIDTH-1:0]   max_d;
    logic [IDX_WIDTH-1:0]    max_idx_q;
    logic [IDX_WIDTH-1:0]    max_idx_d;
    logic                    out_valid_q;
    logic [IDX_WIDTH-1:0]    out_class_q;
    logic [DATA_WIDTH-1:0]   out_score_q;
    logic                    out_err_q;

    logic                    in_fire;
    logic                    beat_wins;
    logic                    at_last_idx;
    logic                    frame_end;
    logic                    frame_err;

    // Ready depends only on state and reset so it can never loop back through in_valid.
    assign in_ready = rst_n && (state_q == ST_ACCUM);
    assign in_fire  = in_valid && in_ready;

    // Running-max update including the current beat; strict compare keeps the earliest index on ties.
    always_comb begin
        beat_wins   = 1'b0;
        at_last_idx = 1'b0;
        frame_end   = 1'b0;
        frame_err   = 1'b0;
        max_d       = max_q;
        max_idx_d   = max_idx_q;
        idx_d       = idx_q;

        at_last_idx = (idx_q == LAST_IDX);
        beat_wins   = (idx_q == '0) || ($signed(in_data) > $signed(max_q));
        frame_end   = in_last || at_last_idx;
        frame_err   = !(in_last && at_last_idx);

        if (beat_wins) begin
            max_d     = in_data;
            max_idx_d = idx_q;
        end

        if (frame_end) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            idx_q       <= '0;
            max_q       <= '0;
            max_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_fire) begin
                        idx_q     <= idx_d;
                        max_q     <= max_d;
                        max_idx_q <= max_idx_d;
                        if (frame_end) begin
                            state_q     <= ST_RESULT;
                            out_valid_q <= 1'b1;
                            out_class_q <= max_idx_d;
                            out_score_q <= max_d;
                            out_err_q   <= frame_err;
                        end
                    end
                end
                ST_RESULT: begin
                    // Result is held unchanged until the consumer takes it.
                    if (out_ready) begin
                        state_q     <= ST_ACCUM;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: queue-based frame model checked every cycle,
// directed frames with literal expectations, then randomized frames/bubbles/backpressure.
module tb_argmax_classifier;

    localparam int DW = 16;
    localparam int N  = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_class;
    logic [DW-1:0] out_score;
    logic          out_err;

    int checks = 0;
    int errors = 0;
    bit rand_oready = 1'b0;
    int fr[16];

    int v_norm[10] = '{5, -3, 12, 7, 12, 0, -8, 1, 2, 3};
    int v_long[10] = '{1, 2, 3, 4, 5, 6, 20, 7, 8, 9};
    int v_bp[10]   = '{-7, 4, 4, -2, 15, 15, 0, 1, -20, 14};

    argmax_classifier #(.DATA_WIDTH(DW), .NUM_OUTPUTS(N), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: gather the frame's beats in a queue, pick the argmax when the frame closes.
    logic signed [DW-1:0] beats[$];
    bit                   m_result = 1'b0;
    logic                 e_valid = 1'b0;
    logic [IW-1:0]        e_class = '0;
    logic [DW-1:0]        e_score = '0;
    logic                 e_err = 1'b0;
    int                   m_best;

    always @(posedge clk) begin
        if (!rst_n) begin
            beats.delete();
            m_result = 1'b0;
            e_valid  = 1'b0;
            e_class  = '0;
            e_score  = '0;
            e_err    = 1'b0;
        end else if (!m_result) begin
            if (in_valid) begin
                beats.push_back($signed(in_data));
                if (in_last || beats.size() == N) begin
                    m_best = 0;
                    for (int i = 1; i < beats.size(); i++)
                        if (beats[i] > beats[m_best]) m_best = i;
                    e_class  = IW'(m_best);
                    e_score  = beats[m_best];
                    e_err    = (in_last && beats.size() == N) ? 1'b0 : 1'b1;
                    e_valid  = 1'b1;
                    m_result = 1'b1;
                    beats.delete();
                end
            end
        end else if (out_ready) begin
            m_result = 1'b0;
            e_valid  = 1'b0;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(rst_n && !m_result));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_class", 32'(out_class), 32'(e_class));
        chk("out_score", 32'(out_score), 32'(e_score));
        chk("out_err",   32'(out_err),   32'(e_err));
    end

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_last  = 1'($urandom);
        if (rand_oready) out_ready = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int  n = 0;
        bit  acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (rand_oready) out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            n++;
            if (!acc && n > 200) begin
                chk("beat_accept_timeout", 32'(0), 32'(1));
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic send_frame(input int n, input bit last_final, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
            send_beat(DW'(fr[i]), last_final && (i == n - 1));
        end
    endtask

    task automatic load10(input int src[10]);
        for (int i = 0; i < 10; i++) fr[i] = src[i];
    endtask

    // Literal check of a result, optional hold under backpressure, then the handshake.
    task automatic wait_result(input string nm, input logic [IW-1:0] cls,
                               input logic [DW-1:0] scr, input logic err, input int hold);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(0));
        chk({nm, "_class"},   32'(out_class), 32'(cls));
        chk({nm, "_score"},   32'(out_score), 32'(scr));
        chk({nm, "_err"},     32'(out_err),   32'(err));
        chk({nm, "_ready0"},  32'(in_ready),  32'(0));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(out_valid), 32'(1));
            chk({nm, "_hold_ready"}, 32'(in_ready),  32'(0));
            chk({nm, "_hold_score"}, 32'(out_score), 32'(scr));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_drop_valid"}, 32'(out_valid), 32'(0));
        chk({nm, "_ready_back"}, 32'(in_ready),  32'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready",  32'(in_ready),  32'(0));
        chk("rst_valid",  32'(out_valid), 32'(0));
        chk("rst_class",  32'(out_class), 32'(0));
        chk("rst_score",  32'(out_score), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;

        load10(v_norm);
        send_frame(10, 1'b1, 1'b0);
        wait_result("normal", 4'd2, 16'd12, 1'b0, 2);

        for (int i = 0; i < 10; i++) fr[i] = -(i + 1);
        send_frame(10, 1'b1, 1'b0);
        wait_result("allneg", 4'd0, 16'hFFFF, 1'b0, 0);

        for (int i = 0; i < 10; i++) fr[i] = -32768;
        send_frame(10, 1'b1, 1'b0);
        wait_result("minval", 4'd0, 16'h8000, 1'b0, 0);

        fr[0] = 3; fr[1] = 9; fr[2] = 1; fr[3] = 4;
        send_frame(4, 1'b1, 1'b0);
        wait_result("short", 4'd1, 16'd9, 1'b1, 0);
        load10(v_norm);
        send_frame(10, 1'b1, 1'b0);
        wait_result("after_short", 4'd2, 16'd12, 1'b0, 0);

        load10(v_long);
        send_frame(10, 1'b0, 1'b0);
        wait_result("long", 4'd6, 16'd20, 1'b1, 0);
        fr[0] = 2; fr[1] = 8; fr[2] = 8;
        send_frame(3, 1'b1, 1'b0);
        wait_result("after_long", 4'd1, 16'd8, 1'b1, 0);

        load10(v_bp);
        send_frame(10, 1'b1, 1'b1);
        wait_result("backpressure", 4'd4, 16'd15, 1'b0, 5);

        for (int i = 0; i < 5; i++) fr[i] = 50;
        send_frame(5, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_class", 32'(out_class), 32'(0));
        chk("midrst_score", 32'(out_score), 32'(0));
        chk("midrst_err",   32'(out_err),   32'(0));
        chk("midrst_ready1", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) fr[i] = i + 1;
        send_frame(10, 1'b1, 1'b0);
        wait_result("post_rst", 4'd9, 16'd10, 1'b0, 0);

        // Random frames: lengths 1..12 split/flagged by the model, random bubbles and backpressure.
        rand_oready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       fr[i] = $urandom_range(0, 3);
                    1:       fr[i] = -32768;
                    default: fr[i] = int'($signed(16'($urandom)));
                endcase
            end
            send_frame(len, 1'b1, 1'b1);
        end
        rand_oready = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
